// File: rtl/uncached_pkg.sv
// Shared types and encodings for the uncached AXI bridge.
package uncached_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/uncached_axi_bridge.sv
// Single-beat uncached CPU-to-AXI bridge; one outstanding access at a time.
// Define UNCACHED_POSTED_WRITE_EN to acknowledge writes at acceptance and finish the AXI write in the background.
module uncached_axi_bridge
    import uncached_pkg::*;
#(
    parameter int BUS_WIDTH = 4
) (
    input  logic                 aclk,
    input  logic                 areset,

    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    input  logic [3:0]           req_wstrb,
    input  logic [1:0]           req_size,

    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    output logic                 posted_err,

    output logic [BUS_WIDTH-1:0] uncached_arid,
    output logic [31:0]          uncached_araddr,
    output logic [3:0]           uncached_arlen,
    output logic [2:0]           uncached_arsize,
    output logic [1:0]           uncached_arburst,
    output logic [1:0]           uncached_arlock,
    output logic [3:0]           uncached_arcache,
    output logic [2:0]           uncached_arprot,
    output logic                 uncached_arvalid,
    input  logic                 uncached_arready,

    input  logic [BUS_WIDTH-1:0] uncached_rid,
    input  logic [31:0]          uncached_rdata,
    input  logic [1:0]           uncached_rresp,
    input  logic                 uncached_rlast,
    input  logic                 uncached_rvalid,
    output logic                 uncached_rready,

    output logic [BUS_WIDTH-1:0] uncached_awid,
    output logic [31:0]          uncached_awaddr,
    output logic [3:0]           uncached_awlen,
    output logic [2:0]           uncached_awsize,
    output logic [1:0]           uncached_awburst,
    output logic [1:0]           uncached_awlock,
    output logic [3:0]           uncached_awcache,
    output logic [2:0]           uncached_awprot,
    output logic                 uncached_awvalid,
    input  logic                 uncached_awready,

    output logic [BUS_WIDTH-1:0] uncached_wid,
    output logic [31:0]          uncached_wdata,
    output logic [3:0]           uncached_wstrb,
    output logic                 uncached_wlast,
    output logic                 uncached_wvalid,
    input  logic                 uncached_wready,

    input  logic [BUS_WIDTH-1:0] uncached_bid,
    input  logic [1:0]           uncached_bresp,
    input  logic                 uncached_bvalid,
    output logic                 uncached_bready
);

    state_t      state, state_n;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  size_q;
    logic        accept;
    logic        arvalid_n, rready_n, awvalid_n, wvalid_n, bready_n;
    logic        resp_valid_n, resp_err_n;
    logic [31:0] resp_rdata_n;
    logic        aw_done, w_done;
    logic        unused_ok;

    assign accept    = req_valid && req_ready;
    assign unused_ok = ^{uncached_rid, uncached_rlast, uncached_rresp[0], uncached_bid, uncached_bresp[0]};

    assign uncached_arid    = '0;
    assign uncached_araddr  = addr_q;
    assign uncached_arlen   = 4'd0;
    assign uncached_arsize  = {1'b0, size_q};
    assign uncached_arburst = AXI_BURST_INCR;
    assign uncached_arlock  = 2'b00;
    assign uncached_arcache = 4'd0;
    assign uncached_arprot  = 3'd0;

    assign uncached_awid    = '0;
    assign uncached_awaddr  = addr_q;
    assign uncached_awlen   = 4'd0;
    assign uncached_awsize  = {1'b0, size_q};
    assign uncached_awburst = AXI_BURST_INCR;
    assign uncached_awlock  = 2'b00;
    assign uncached_awcache = 4'd0;
    assign uncached_awprot  = 3'd0;

    assign uncached_wid     = '0;
    assign uncached_wdata   = wdata_q;
    assign uncached_wstrb   = wstrb_q;
    assign uncached_wlast   = 1'b1;

    always_comb begin
        state_n      = state;
        arvalid_n    = uncached_arvalid;
        rready_n     = uncached_rready;
        awvalid_n    = uncached_awvalid;
        wvalid_n     = uncached_wvalid;
        bready_n     = uncached_bready;
        resp_valid_n = 1'b0;
        resp_rdata_n = resp_rdata;
        resp_err_n   = resp_err;
        // A channel counts as done once its valid has already dropped or handshakes now.
        aw_done      = !uncached_awvalid || uncached_awready;
        w_done       = !uncached_wvalid || uncached_wready;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_we) begin
                        state_n   = WR_REQ;
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
`ifdef UNCACHED_POSTED_WRITE_EN
                        resp_valid_n = 1'b1;
                        resp_rdata_n = '0;
                        resp_err_n   = 1'b0;
`endif
                    end else begin
                        state_n   = RD_ADDR;
                        arvalid_n = 1'b1;
                    end
                end
            end
            RD_ADDR: begin
                if (uncached_arready) begin
                    arvalid_n = 1'b0;
                    rready_n  = 1'b1;
                    state_n   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (uncached_rvalid) begin
                    rready_n     = 1'b0;
                    state_n      = IDLE;
                    resp_valid_n = 1'b1;
                    resp_rdata_n = uncached_rdata;
                    resp_err_n   = uncached_rresp[1];
                end
            end
            WR_REQ: begin
                if (uncached_awready) awvalid_n = 1'b0;
                if (uncached_wready)  wvalid_n  = 1'b0;
                if (aw_done && w_done) begin
                    state_n  = WR_RESP;
                    bready_n = 1'b1;
                end
            end
            WR_RESP: begin
                if (uncached_bvalid) begin
                    bready_n = 1'b0;
                    state_n  = IDLE;
`ifndef UNCACHED_POSTED_WRITE_EN
                    resp_valid_n = 1'b1;
                    resp_rdata_n = '0;
                    resp_err_n   = uncached_bresp[1];
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state            <= IDLE;
            req_ready        <= 1'b0;
            uncached_arvalid <= 1'b0;
            uncached_rready  <= 1'b0;
            uncached_awvalid <= 1'b0;
            uncached_wvalid  <= 1'b0;
            uncached_bready  <= 1'b0;
            resp_valid       <= 1'b0;
            resp_rdata       <= '0;
            resp_err         <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= '0;
            wstrb_q          <= '0;
            size_q           <= '0;
        end else begin
            state            <= state_n;
            // Background posted writes keep the FSM busy, so IDLE alone gates new requests.
            req_ready        <= (state_n == IDLE);
            uncached_arvalid <= arvalid_n;
            uncached_rready  <= rready_n;
            uncached_awvalid <= awvalid_n;
            uncached_wvalid  <= wvalid_n;
            uncached_bready  <= bready_n;
            resp_valid       <= resp_valid_n;
            resp_rdata       <= resp_rdata_n;
            resp_err         <= resp_err_n;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
                size_q  <= req_size;
            end
        end
    end

`ifdef UNCACHED_POSTED_WRITE_EN
    always_ff @(posedge aclk) begin
        if (areset)
            posted_err <= 1'b0;
        else if (state == WR_RESP && uncached_bvalid && uncached_bresp[1])
            posted_err <= 1'b1;
    end
`else
    assign posted_err = 1'b0;
`endif

endmodule

// File: tb/tb_uncached_axi_bridge.sv
// Directed bench for uncached_axi_bridge; posted-write checks build when UNCACHED_POSTED_WRITE_EN is defined.
module tb_uncached_axi_bridge;

`ifdef UNCACHED_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        areset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic [1:0]  req_size;
    logic        resp_valid, resp_err, posted_err;
    logic [31:0] resp_rdata;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [3:0]  arlen, awlen, arcache, awcache, wstrb;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int tests = 0;
    int failed = 0;
    int aw_hs = 0;
    int w_hs = 0;

    always #5 aclk = ~aclk;

    uncached_axi_bridge #(.BUS_WIDTH(4)) dut (
        .aclk(aclk), .areset(areset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_size(req_size),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .posted_err(posted_err),
        .uncached_arid(arid), .uncached_araddr(araddr), .uncached_arlen(arlen), .uncached_arsize(arsize),
        .uncached_arburst(arburst), .uncached_arlock(arlock), .uncached_arcache(arcache),
        .uncached_arprot(arprot), .uncached_arvalid(arvalid), .uncached_arready(arready),
        .uncached_rid(rid), .uncached_rdata(rdata), .uncached_rresp(rresp), .uncached_rlast(rlast),
        .uncached_rvalid(rvalid), .uncached_rready(rready),
        .uncached_awid(awid), .uncached_awaddr(awaddr), .uncached_awlen(awlen), .uncached_awsize(awsize),
        .uncached_awburst(awburst), .uncached_awlock(awlock), .uncached_awcache(awcache),
        .uncached_awprot(awprot), .uncached_awvalid(awvalid), .uncached_awready(awready),
        .uncached_wid(wid), .uncached_wdata(wdata), .uncached_wstrb(wstrb), .uncached_wlast(wlast),
        .uncached_wvalid(wvalid), .uncached_wready(wready),
        .uncached_bid(bid), .uncached_bresp(bresp), .uncached_bvalid(bvalid), .uncached_bready(bready)
    );

    always @(posedge aclk) begin
        if (awvalid && awready) aw_hs <= aw_hs + 1;
        if (wvalid && wready)   w_hs  <= w_hs + 1;
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        areset = 1'b1;  req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_wstrb = '0; req_size = '0;
        arready = 1'b0; rid = 4'h5; rdata = '0; rresp = '0; rlast = 1'b1; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = 4'h3; bresp = '0; bvalid = 1'b0;
        tick(); tick(); tick();

        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_bready", bready, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_posted_err", posted_err, 0);

        areset = 1'b0;
        tick();
        chk("rel_req_ready", req_ready, 1);

        // Minimum-latency read of 0x1FD0_F000.
        arready = 1'b1; rvalid = 1'b1; rdata = 32'hDEADBEEF; rresp = 2'b00;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h1FD0_F000; req_size = 2'd2;
        tick();
        req_valid = 1'b0;
        chk("rd1_c1_arvalid", arvalid, 1);
        chk("rd1_c1_araddr", araddr, 32'h1FD0_F000);
        chk("rd1_c1_arsize", arsize, 3'b010);
        chk("rd1_c1_arburst", arburst, 2'b01);
        chk("rd1_c1_arlen", arlen, 0);
        chk("rd1_c1_arid", arid, 0);
        chk("rd1_c1_req_ready", req_ready, 0);
        chk("rd1_c1_rready", rready, 0);
        tick();
        chk("rd1_c2_rready", rready, 1);
        chk("rd1_c2_arvalid", arvalid, 0);
        chk("rd1_c2_resp_valid", resp_valid, 0);
        tick();
        rvalid = 1'b0;
        chk("rd1_c3_resp_valid", resp_valid, 1);
        chk("rd1_c3_resp_rdata", resp_rdata, 32'hDEADBEEF);
        chk("rd1_c3_resp_err", resp_err, 0);
        chk("rd1_c3_req_ready", req_ready, 1);
        tick();
        chk("rd1_c4_resp_pulse", resp_valid, 0);

        // Byte read returning SLVERR.
        rvalid = 1'b1; rdata = 32'h0000_0055; rresp = 2'b10;
        req_valid = 1'b1; req_addr = 32'h1000_0003; req_size = 2'd0;
        tick();
        req_valid = 1'b0;
        chk("rd2_arsize", arsize, 3'b000);
        chk("rd2_araddr", araddr, 32'h1000_0003);
        tick(); tick();
        rvalid = 1'b0; rresp = 2'b00;
        chk("rd2_resp_valid", resp_valid, 1);
        chk("rd2_resp_err", resp_err, 1);
        chk("rd2_resp_rdata", resp_rdata, 32'h55);
        arready = 1'b0;
        tick();

        // Write with W accepted three cycles ahead of AW.
        wready = 1'b1; awready = 1'b0; bvalid = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h2000_0010;
        req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF; req_size = 2'd2;
        tick();
        req_valid = 1'b0;
        chk("wr1_c1_awvalid", awvalid, 1);
        chk("wr1_c1_wvalid", wvalid, 1);
        chk("wr1_c1_wdata", wdata, 32'hCAFEF00D);
        chk("wr1_c1_awaddr", awaddr, 32'h2000_0010);
        chk("wr1_c1_wlast", wlast, 1);
        chk("wr1_c1_resp_valid", resp_valid, POSTED ? 1 : 0);
        tick();
        chk("wr1_c2_wvalid", wvalid, 0);
        chk("wr1_c2_awvalid", awvalid, 1);
        chk("wr1_c2_bready", bready, 0);
        tick();
        chk("wr1_c3_awvalid", awvalid, 1);
        chk("wr1_c3_bready", bready, 0);
        tick();
        awready = 1'b1;
        chk("wr1_c4_bready", bready, 0);
        tick();
        awready = 1'b0;
        chk("wr1_c5_awvalid", awvalid, 0);
        chk("wr1_c5_bready", bready, 1);
        chk("wr1_c5_resp_valid", resp_valid, 0);
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        chk("wr1_c6_resp_valid", resp_valid, POSTED ? 0 : 1);
        chk("wr1_c6_resp_rdata", resp_rdata, 0);
        chk("wr1_c6_resp_err", resp_err, 0);
        chk("wr1_aw_handshakes", aw_hs, 1);
        chk("wr1_w_handshakes", w_hs, 1);
        chk("wr1_c6_bready", bready, 0);
        tick();

        // Minimum-latency write returning SLVERR.
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b10;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h2000_0020; req_wdata = 32'h1234_5678;
        req_wstrb = 4'h3; req_size = 2'd1;
        tick();
        req_valid = 1'b0;
        chk("wr2_c1_awvalid", awvalid, 1);
        chk("wr2_c1_awsize", awsize, 3'b001);
        chk("wr2_c1_wstrb", wstrb, 4'h3);
        tick();
        chk("wr2_c2_bready", bready, 1);
        tick();
        bvalid = 1'b0; bresp = 2'b00;
        chk("wr2_c3_resp_valid", resp_valid, POSTED ? 0 : 1);
        chk("wr2_c3_resp_err", resp_err, POSTED ? 0 : 1);
        chk("wr2_c3_posted_err", posted_err, POSTED ? 1 : 0);
        chk("wr2_c3_req_ready", req_ready, 1);
        awready = 1'b0; wready = 1'b0;
        tick();

        // Reset pulsed while waiting in RD_DATA.
        arready = 1'b1; rvalid = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h3000_0000; req_size = 2'd2;
        tick();
        req_valid = 1'b0;
        tick();
        chk("rst2_in_rd_data", rready, 1);
        areset = 1'b1; rvalid = 1'b1; rdata = 32'hFFFF_0000;
        tick();
        chk("rst2_arvalid", arvalid, 0);
        chk("rst2_rready", rready, 0);
        chk("rst2_resp_valid", resp_valid, 0);
        chk("rst2_req_ready", req_ready, 0);
        chk("rst2_posted_err", posted_err, 0);
        areset = 1'b0;
        tick();
        rvalid = 1'b0;
        chk("rst2_rel_req_ready", req_ready, 1);
        chk("rst2_rel_resp_valid", resp_valid, 0);
        chk("rst2_rel_resp_rdata", resp_rdata, 0);
        tick();

`ifdef UNCACHED_POSTED_WRITE_EN
        // Posted write: early ack, following read stalls until B, DECERR sets the sticky flag.
        awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h4000_0000; req_wdata = 32'hA5A5_A5A5;
        req_wstrb = 4'hF;
        tick();
        req_we = 1'b0; req_addr = 32'h4000_0004;
        chk("pw_c1_resp_valid", resp_valid, 1);
        chk("pw_c1_resp_err", resp_err, 0);
        chk("pw_c1_req_ready", req_ready, 0);
        tick();
        chk("pw_c2_req_ready", req_ready, 0);
        chk("pw_c2_arvalid", arvalid, 0);
        chk("pw_c2_bready", bready, 1);
        chk("pw_c2_resp_valid", resp_valid, 0);
        bvalid = 1'b1; bresp = 2'b11;
        tick();
        bvalid = 1'b0; bresp = 2'b00;
        chk("pw_c3_posted_err", posted_err, 1);
        chk("pw_c3_req_ready", req_ready, 1);
        chk("pw_c3_resp_valid", resp_valid, 0);
        tick();
        req_valid = 1'b0;
        chk("pw_c4_rd_arvalid", arvalid, 1);
        chk("pw_c4_rd_araddr", araddr, 32'h4000_0004);
        chk("pw_c4_posted_err", posted_err, 1);
        rvalid = 1'b1; rdata = 32'h0BAD_F00D;
        tick(); tick();
        rvalid = 1'b0;
        chk("pw_rd_resp_rdata", resp_rdata, 32'h0BAD_F00D);
        chk("pw_sticky", posted_err, 1);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        chk("pw_rst_clears", posted_err, 0);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
